ffe: RTL and testbench

FFE -- requirements
Module: ffe

---
 rtl/ffe.sv | 123 ++++++++++++
 tb/tb_ffe.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/ffe.sv
// Multi-lane FIR feed-forward equalizer with a TL-UL register port for the
// tap weights; LANES samples per cycle, one-cycle registered latency.
module ffe #(
  parameter int NTAPS = 5,
  parameter int LANES = 4,
  parameter int FRAC  = 6
) (
  input  logic        clock,
  input  logic        reset,
  output logic        auto_reg_in_a_ready,
  input  logic        auto_reg_in_a_valid,
  input  logic [2:0]  auto_reg_in_a_bits_opcode,
  input  logic [2:0]  auto_reg_in_a_bits_param,
  input  logic [1:0]  auto_reg_in_a_bits_size,
  input  logic [2:0]  auto_reg_in_a_bits_source,
  input  logic [10:0] auto_reg_in_a_bits_address,
  input  logic [7:0]  auto_reg_in_a_bits_mask,
  input  logic [63:0] auto_reg_in_a_bits_data,
  input  logic        auto_reg_in_a_bits_corrupt,
  input  logic        auto_reg_in_d_ready,
  output logic        auto_reg_in_d_valid,
  output logic [2:0]  auto_reg_in_d_bits_opcode,
  output logic [1:0]  auto_reg_in_d_bits_size,
  output logic [2:0]  auto_reg_in_d_bits_source,
  input  logic        io_in_valid,
  input  logic [7:0]  io_in_bits_0,
  input  logic [7:0]  io_in_bits_1,
  input  logic [7:0]  io_in_bits_2,
  input  logic [7:0]  io_in_bits_3,
  output logic        io_out_valid,
  output logic [7:0]  io_out_bits_0,
  output logic [7:0]  io_out_bits_1,
  output logic [7:0]  io_out_bits_2,
  output logic [7:0]  io_out_bits_3
);

  localparam int ACCW = 16 + $clog2(NTAPS) + 1;
  localparam logic signed [ACCW-1:0] MAXV = 127;
  localparam logic signed [ACCW-1:0] MINV = -128;

  logic signed [7:0]      w    [NTAPS];
  logic signed [7:0]      hist [LANES];
  logic signed [7:0]      outr [LANES];
  logic signed [7:0]      smp  [2*LANES];
  logic signed [7:0]      res  [LANES];
  logic signed [ACCW-1:0] acc;
  logic signed [ACCW-1:0] sh;
  logic signed [15:0]     prod;
  logic [7:0]             idx;
  logic                   wr_en;
  logic                   unused;

  assign auto_reg_in_a_ready       = auto_reg_in_d_ready;
  assign auto_reg_in_d_valid       = auto_reg_in_a_valid;
  assign auto_reg_in_d_bits_opcode = (auto_reg_in_a_bits_opcode == 3'd4) ? 3'd1 : 3'd0;
  assign auto_reg_in_d_bits_size   = auto_reg_in_a_bits_size;
  assign auto_reg_in_d_bits_source = auto_reg_in_a_bits_source;

  assign idx   = auto_reg_in_a_bits_address[10:3];
  assign wr_en = auto_reg_in_a_valid && auto_reg_in_d_ready && auto_reg_in_a_bits_mask[0] &&
                 (auto_reg_in_a_bits_opcode == 3'd0 || auto_reg_in_a_bits_opcode == 3'd1);

  assign unused = ^{auto_reg_in_a_bits_param, auto_reg_in_a_bits_corrupt,
                    auto_reg_in_a_bits_address[2:0], auto_reg_in_a_bits_mask[7:1],
                    auto_reg_in_a_bits_data[63:8]};

  // Window of 2*LANES samples: history (older) in the low half, current word above.
  always_comb begin
    for (int unsigned i = 0; i < LANES; i++) smp[i] = hist[i];
    smp[LANES+0] = io_in_bits_0;
    smp[LANES+1] = io_in_bits_1;
    smp[LANES+2] = io_in_bits_2;
    smp[LANES+3] = io_in_bits_3;
  end

  always_comb begin
    acc  = '0;
    sh   = '0;
    prod = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      acc = '0;
      for (int unsigned k = 0; k < NTAPS; k++) begin
        if (LANES + i >= k) begin
          prod = w[k] * smp[LANES+i-k];
          acc  = acc + ACCW'(prod);
        end
      end
      sh = acc >>> FRAC;
      if (sh > MAXV)      res[i] = 8'sd127;
      else if (sh < MINV) res[i] = -8'sd128;
      else                res[i] = sh[7:0];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      io_out_valid <= 1'b0;
      for (int unsigned i = 0; i < LANES; i++) begin
        hist[i] <= '0;
        outr[i] <= '0;
      end
      for (int unsigned k = 0; k < NTAPS; k++) w[k] <= (k == 0) ? 8'(1 << FRAC) : '0;
    end else begin
      io_out_valid <= io_in_valid;
      if (io_in_valid) begin
        for (int unsigned i = 0; i < LANES; i++) begin
          hist[i] <= smp[LANES+i];
          outr[i] <= res[i];
        end
      end
      if (wr_en) begin
        for (int unsigned k = 0; k < NTAPS; k++)
          if (idx == 8'(k)) w[k] <= auto_reg_in_a_bits_data[7:0];
      end
    end
  end

  assign io_out_bits_0 = outr[0];
  assign io_out_bits_1 = outr[1];
  assign io_out_bits_2 = outr[2];
  assign io_out_bits_3 = outr[3];

endmodule

// File: tb/tb_ffe.sv
// Self-checking bench for ffe: reference FIR model feeds a scoreboard queue,
// plus directed constant checks on the register port and key vectors.
module tb_ffe;

  logic        clock = 1'b0;
  logic        reset;
  logic        a_ready, a_valid, a_corrupt, d_ready, d_valid;
  logic [2:0]  a_opcode, a_param, a_source, d_opcode, d_source;
  logic [1:0]  a_size, d_size;
  logic [10:0] a_address;
  logic [7:0]  a_mask;
  logic [63:0] a_data;
  logic        in_valid, out_valid;
  logic [7:0]  in0, in1, in2, in3, o0, o1, o2, o3;
  logic [31:0] out_word;

  int n_checks = 0;
  int n_pass   = 0;
  int mw [5];
  int mhist [4];
  logic [31:0] sb [$];

  always #5 clock = ~clock;
  assign out_word = {o3, o2, o1, o0};

  ffe #(.NTAPS(5), .LANES(4), .FRAC(6)) dut (
    .clock(clock), .reset(reset),
    .auto_reg_in_a_ready(a_ready), .auto_reg_in_a_valid(a_valid),
    .auto_reg_in_a_bits_opcode(a_opcode), .auto_reg_in_a_bits_param(a_param),
    .auto_reg_in_a_bits_size(a_size), .auto_reg_in_a_bits_source(a_source),
    .auto_reg_in_a_bits_address(a_address), .auto_reg_in_a_bits_mask(a_mask),
    .auto_reg_in_a_bits_data(a_data), .auto_reg_in_a_bits_corrupt(a_corrupt),
    .auto_reg_in_d_ready(d_ready), .auto_reg_in_d_valid(d_valid),
    .auto_reg_in_d_bits_opcode(d_opcode), .auto_reg_in_d_bits_size(d_size),
    .auto_reg_in_d_bits_source(d_source),
    .io_in_valid(in_valid), .io_in_bits_0(in0), .io_in_bits_1(in1),
    .io_in_bits_2(in2), .io_in_bits_3(in3),
    .io_out_valid(out_valid), .io_out_bits_0(o0), .io_out_bits_1(o1),
    .io_out_bits_2(o2), .io_out_bits_3(o3)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic model_reset();
    for (int k = 0; k < 5; k++) mw[k] = (k == 0) ? 64 : 0;
    for (int i = 0; i < 4; i++) mhist[i] = 0;
    sb.delete();
  endtask

  // Reference: direct convolution with floor division and clamp.
  function automatic logic [31:0] model(input int x0, input int x1, input int x2, input int x3);
    int x [4];
    int acc, s, q;
    logic [31:0] r;
    x[0] = x0; x[1] = x1; x[2] = x2; x[3] = x3;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      acc = 0;
      for (int k = 0; k < 5; k++) begin
        if (i - k >= 0) s = x[i-k];
        else            s = mhist[i-k+4];
        acc += mw[k] * s;
      end
      q = acc / 64;
      if (acc < 0 && (acc % 64) != 0) q -= 1;
      if (q > 127)  q = 127;
      if (q < -128) q = -128;
      r[8*i +: 8] = 8'(q);
    end
    return r;
  endfunction

  task automatic send(input int x0, input int x1, input int x2, input int x3, input logic v);
    logic [31:0] held, exp;
    held = out_word;
    in0 = 8'(x0); in1 = 8'(x1); in2 = 8'(x2); in3 = 8'(x3);
    in_valid = v;
    if (v) begin
      sb.push_back(model(x0, x1, x2, x3));
      mhist[0] = x0; mhist[1] = x1; mhist[2] = x2; mhist[3] = x3;
    end
    @(posedge clock); #1;
    in_valid = 1'b0;
    check("out_valid", 32'(out_valid), 32'(v));
    if (out_valid) begin
      if (sb.size() == 0) check("sb_empty", 32'(1), 32'(0));
      else begin
        exp = sb.pop_front();
        check("out_word", out_word, exp);
      end
    end else begin
      check("out_hold", out_word, held);
    end
  endtask

  task automatic tl(input logic [2:0] op, input logic [10:0] addr, input logic [7:0] mask,
                    input logic [63:0] data, input logic [2:0] src);
    a_opcode = op; a_address = addr; a_mask = mask; a_data = data;
    a_source = src; a_size = 2'd3; a_valid = 1'b1; d_ready = 1'b1;
    #1;
    check("d_valid", 32'(d_valid), 32'(1));
    check("a_ready", 32'(a_ready), 32'(1));
    check("d_opcode", 32'(d_opcode), (op == 3'd4) ? 32'(1) : 32'(0));
    check("d_source", 32'(d_source), 32'(src));
    check("d_size", 32'(d_size), 32'(3));
    @(posedge clock); #1;
    a_valid = 1'b0;
    if (op != 3'd4 && mask[0] && addr[10:3] < 8'd5) mw[addr[10:3]] = int'($signed(data[7:0]));
  endtask

  initial begin
    reset = 1'b1; a_valid = 1'b0; d_ready = 1'b1; a_opcode = '0; a_param = '0;
    a_size = '0; a_source = '0; a_address = '0; a_mask = '0; a_data = '0; a_corrupt = 1'b0;
    in_valid = 1'b0; in0 = '0; in1 = '0; in2 = '0; in3 = '0;
    model_reset();
    repeat (5) @(posedge clock);
    #1 reset = 1'b0;
    check("rst_valid", 32'(out_valid), 32'(0));
    check("rst_bits", out_word, 32'h0);

    send(10, 20, -5, 127, 1'b1);
    check("identity", out_word, 32'h7FFB140A);

    d_ready = 1'b0; a_valid = 1'b1; #1;
    check("a_ready_low", 32'(a_ready), 32'(0));
    @(posedge clock); #1 a_valid = 1'b0; d_ready = 1'b1;

    tl(3'd0, 11'h000, 8'h01, 64'h0, 3'd1);
    tl(3'd0, 11'h008, 8'h01, 64'h40, 3'd2);
    send(0, 0, 0, 0, 1'b1);
    send(1, 2, 3, 4, 1'b1);
    check("delay_a", out_word, 32'h03020100);
    send(5, 6, 7, 8, 1'b1);
    check("delay_b", out_word, 32'h07060504);
    send(99, 99, 99, 99, 1'b0);
    send(9, 10, 11, 12, 1'b1);
    check("gap_cont", out_word, 32'h0B0A0908);

    tl(3'd0, 11'h008, 8'h01, 64'h0, 3'd3);
    tl(3'd1, 11'h000, 8'h01, 64'h7F, 3'd4);
    send(127, 127, 127, 127, 1'b1);
    check("sat_pos", out_word, 32'h7F7F7F7F);
    send(-128, -128, -128, -128, 1'b1);
    check("sat_neg", out_word, 32'h80808080);

    tl(3'd0, 11'h000, 8'h01, 64'h20, 3'd0);
    send(3, -3, 1, -1, 1'b1);
    check("floor", out_word, 32'hFF00FE01);

    tl(3'd4, 11'h010, 8'h01, 64'h0, 3'd5);
    tl(3'd0, 11'h040, 8'h01, 64'h0, 3'd6);
    tl(3'd0, 11'h000, 8'h00, 64'h0, 3'd7);
    send(64, 2, -2, 0, 1'b1);
    check("unmapped", out_word, 32'h00FF0120);

    in0 = 8'd50; in1 = 8'd50; in2 = 8'd50; in3 = 8'd50; in_valid = 1'b1; reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0; in_valid = 1'b0;
    model_reset();
    check("mid_rst_valid", 32'(out_valid), 32'(0));
    check("mid_rst_bits", out_word, 32'h0);
    tl(3'd0, 11'h008, 8'h01, 64'h40, 3'd1);
    send(1, 2, 3, 4, 1'b1);
    check("post_rst_hist", out_word, 32'h07050301);
    send(-7, 100, -100, 33, 1'b1);
    send(60, -60, 90, -90, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
